// File: rtl/floor_indicator_if.sv
// Status lines from the movement controller and the passenger-facing display outputs.
// The controller side uses the master modport; the indicator uses the slave modport.
interface floor_indicator_if;
  logic       floor1;
  logic       floor2;
  logic       floor3;
  logic       door;
  logic       moving;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic [6:0] seg;
  logic       dir_up;
  logic       dir_down;
  logic       chime;
  logic       alarm_led;
  logic       fault;

  modport master (
    output floor1, floor2, floor3, door, moving, sos_mode, weight_limit_exceeded,
    input  seg, dir_up, dir_down, chime, alarm_led, fault
  );

  modport slave (
    input  floor1, floor2, floor3, door, moving, sos_mode, weight_limit_exceeded,
    output seg, dir_up, dir_down, chime, alarm_led, fault
  );
endinterface

// File: rtl/floor_indicator.sv
// Floor indicator: debounced floor digit, direction arrows, arrival chime and alarm blink.
// Define ARRIVAL_CHIME_EN to build the ARRIVE state and chime pulse; otherwise chime is tied low.
module floor_indicator #(
  parameter int SETTLE_CYCLES = 2,
  parameter int BLINK_DIV     = 25,
  parameter int CHIME_CYCLES  = 4
) (
  input logic               clk,
  input logic               rst_n,
  floor_indicator_if.slave  ind
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_F1   = 7'b0000110;
  localparam logic [6:0] SEG_F2   = 7'b1011011;
  localparam logic [6:0] SEG_F3   = 7'b1001111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
`ifdef ARRIVAL_CHIME_EN
    ARRIVE = 2'd2,
`endif
    ALERT  = 2'd3
  } state_t;

  function automatic logic [1:0] floor_num(input logic [2:0] pat);
    case (pat)
      3'b001:  floor_num = 2'd1;
      3'b010:  floor_num = 2'd2;
      3'b100:  floor_num = 2'd3;
      default: floor_num = 2'd0;
    endcase
  endfunction

  function automatic logic [6:0] seg_code(input logic [2:0] pat);
    case (pat)
      3'b001:  seg_code = SEG_F1;
      3'b010:  seg_code = SEG_F2;
      3'b100:  seg_code = SEG_F3;
      default: seg_code = SEG_DASH;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      samp_q, cand_q, cand_d, acc_q, acc_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic            accept;
  logic [1:0]      last_q, last_d, new_floor;
  logic [BW-1:0]   blink_q, blink_d;
  logic            blank_q, blank_d;
  logic [6:0]      seg_q, seg_d;
  logic            up_q, up_d, down_q, down_d;
  logic            alarm_q, alarm_d, fault_q, fault_d;
  logic            alarm_in;

`ifdef ARRIVAL_CHIME_EN
  localparam int CW = $clog2(CHIME_CYCLES + 1);
  localparam logic [CW-1:0] CHIME_MAX = CW'(CHIME_CYCLES);
  logic [CW-1:0]   chime_cnt_q, chime_cnt_d;
  logic            chime_q, chime_d;
`endif

  assign alarm_in = ind.sos_mode | ind.weight_limit_exceeded;

  // A candidate pattern must be seen SETTLE_CYCLES samples in a row; acceptance and
  // the display update happen on the same edge so outputs land SETTLE_CYCLES+1 edges in.
  always_comb begin
    stab_d = stab_q;
    cand_d = samp_q;
    acc_d  = acc_q;
    accept = 1'b0;
    if (samp_q == acc_q) begin
      stab_d = '0;
    end else begin
      if (samp_q == cand_q)
        stab_d = (stab_q == SETTLE_MAX) ? stab_q : stab_q + 1'b1;
      else
        stab_d = SW'(1);
      if (stab_d == SETTLE_MAX) begin
        accept = 1'b1;
        acc_d  = samp_q;
        stab_d = '0;
      end
    end
  end

  always_comb begin
    up_d      = up_q;
    down_d    = down_q;
    last_d    = last_q;
    new_floor = floor_num(acc_d);
    if (accept && new_floor != 2'd0) begin
      last_d = new_floor;
      if (new_floor > last_q) begin
        up_d   = 1'b1;
        down_d = 1'b0;
      end else if (new_floor < last_q) begin
        up_d   = 1'b0;
        down_d = 1'b1;
      end
    end
    if (state_q == IDLE && ind.door) begin
      up_d   = 1'b0;
      down_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    blink_d = '0;
    blank_d = 1'b0;
`ifdef ARRIVAL_CHIME_EN
    chime_cnt_d = chime_cnt_q;
    chime_d     = chime_q;
`endif
    if (alarm_in) begin
      state_d = ALERT;
`ifdef ARRIVAL_CHIME_EN
      chime_cnt_d = '0;
      chime_d     = 1'b0;
`endif
      if (state_q == ALERT) begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          blank_d = ~blank_q;
        end else begin
          blink_d = blink_q + 1'b1;
          blank_d = blank_q;
        end
      end
    end else begin
      case (state_q)
        IDLE:   if (ind.moving) state_d = TRAVEL;
        TRAVEL: if (!ind.moving) begin
`ifdef ARRIVAL_CHIME_EN
          state_d     = ARRIVE;
          chime_cnt_d = CHIME_MAX;
          chime_d     = 1'b1;
`else
          state_d = IDLE;
`endif
        end
`ifdef ARRIVAL_CHIME_EN
        ARRIVE: begin
          if (ind.moving) begin
            state_d     = TRAVEL;
            chime_cnt_d = '0;
            chime_d     = 1'b0;
          end else if (chime_cnt_q <= CW'(1)) begin
            state_d     = IDLE;
            chime_cnt_d = '0;
            chime_d     = 1'b0;
          end else begin
            chime_cnt_d = chime_cnt_q - 1'b1;
          end
        end
`endif
        ALERT:   state_d = ind.moving ? TRAVEL : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    seg_d   = (state_d == ALERT && blank_d) ? '0 : seg_code(acc_d);
    fault_d = (floor_num(acc_d) == 2'd0);
    alarm_d = (state_d == ALERT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      samp_q  <= 3'b001;
      cand_q  <= 3'b001;
      acc_q   <= 3'b001;
      stab_q  <= '0;
      last_q  <= 2'd1;
      blink_q <= '0;
      blank_q <= 1'b0;
      seg_q   <= SEG_F1;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      alarm_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= {ind.floor3, ind.floor2, ind.floor1};
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      stab_q  <= stab_d;
      last_q  <= last_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      up_q    <= up_d;
      down_q  <= down_d;
      alarm_q <= alarm_d;
      fault_q <= fault_d;
    end
  end

`ifdef ARRIVAL_CHIME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chime_cnt_q <= '0;
      chime_q     <= 1'b0;
    end else begin
      chime_cnt_q <= chime_cnt_d;
      chime_q     <= chime_d;
    end
  end
  assign ind.chime = chime_q;
`else
  assign ind.chime = 1'b0;
`endif

  assign ind.seg       = seg_q;
  assign ind.dir_up    = up_q;
  assign ind.dir_down  = down_q;
  assign ind.alarm_led = alarm_q;
  assign ind.fault     = fault_q;

endmodule

// File: tb/tb_floor_indicator.sv
// Directed bench for floor_indicator; chime expectations follow ARRIVAL_CHIME_EN.
module tb_floor_indicator;

`ifdef ARRIVAL_CHIME_EN
  localparam bit HAS_CHIME = 1'b1;
`else
  localparam bit HAS_CHIME = 1'b0;
`endif

  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] SD = 7'b1000000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  floor_indicator_if bus ();

  floor_indicator #(
    .SETTLE_CYCLES(2),
    .BLINK_DIV(25),
    .CHIME_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ind(bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_floor(input logic [2:0] f);
    {bus.floor3, bus.floor2, bus.floor1} = f;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_floor(3'b001);
    bus.door = 1'b0; bus.moving = 1'b0;
    bus.sos_mode = 1'b0; bus.weight_limit_exceeded = 1'b0;
    #12;
    checks++;
    if (bus.seg !== S1) begin failures++; $display("FAIL reset_seg got=%b exp=%b", bus.seg, S1); end
    checks++;
    if ({bus.dir_up, bus.dir_down, bus.chime, bus.alarm_led, bus.fault} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000",
        {bus.dir_up, bus.dir_down, bus.chime, bus.alarm_led, bus.fault});
    end
    @(negedge clk) rst_n = 1'b1;
    step(3);
    checks++;
    if (bus.seg !== S1 || bus.fault !== 1'b0) begin
      failures++; $display("FAIL post_reset_seg got=%b/%b exp=%b/0", bus.seg, bus.fault, S1);
    end
  endtask

  task automatic test_floor_up;
    set_floor(3'b010);
    step(2);
    checks++;
    if (bus.seg !== S1) begin failures++; $display("FAIL settle_hold got=%b exp=%b", bus.seg, S1); end
    step(1);
    checks++;
    if (bus.seg !== S2) begin failures++; $display("FAIL settle_seg2 got=%b exp=%b", bus.seg, S2); end
    checks++;
    if ({bus.dir_up, bus.dir_down} !== 2'b10) begin
      failures++; $display("FAIL dir_up_1to2 got=%b exp=10", {bus.dir_up, bus.dir_down});
    end
  endtask

  task automatic test_glitch;
    set_floor(3'b100);
    step(1);
    set_floor(3'b010);
    step(5);
    checks++;
    if (bus.seg !== S2) begin failures++; $display("FAIL glitch_seg got=%b exp=%b", bus.seg, S2); end
    checks++;
    if (bus.fault !== 1'b0) begin failures++; $display("FAIL glitch_fault got=%b exp=0", bus.fault); end
  endtask

  task automatic test_chime;
    logic exp;
    bus.moving = 1'b1;
    step(2);
    checks++;
    if (bus.chime !== 1'b0) begin failures++; $display("FAIL travel_chime got=%b exp=0", bus.chime); end
    bus.moving = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp = HAS_CHIME && (i <= 4);
      checks++;
      if (bus.chime !== exp) begin
        failures++; $display("FAIL chime_cycle%0d got=%b exp=%b", i, bus.chime, exp);
      end
    end
    checks++;
    if ({bus.dir_up, bus.dir_down} !== 2'b10) begin
      failures++; $display("FAIL dir_hold_arrive got=%b exp=10", {bus.dir_up, bus.dir_down});
    end
    bus.door = 1'b1;
    step(1);
    checks++;
    if ({bus.dir_up, bus.dir_down} !== 2'b00) begin
      failures++; $display("FAIL door_clear_dir got=%b exp=00", {bus.dir_up, bus.dir_down});
    end
    bus.door = 1'b0;
    step(1);
  endtask

  task automatic test_alarm;
    bus.moving = 1'b1;
    step(2);
    bus.moving = 1'b0;
    step(2);
    checks++;
    if (bus.chime !== HAS_CHIME) begin
      failures++; $display("FAIL pre_alarm_chime got=%b exp=%b", bus.chime, HAS_CHIME);
    end
    bus.sos_mode = 1'b1;
    step(1);
    checks++;
    if (bus.chime !== 1'b0) begin failures++; $display("FAIL alarm_chime_abort got=%b exp=0", bus.chime); end
    checks++;
    if (bus.alarm_led !== 1'b1) begin failures++; $display("FAIL alarm_led_on got=%b exp=1", bus.alarm_led); end
    checks++;
    if (bus.seg !== S2) begin failures++; $display("FAIL blink_first got=%b exp=%b", bus.seg, S2); end
    step(24);
    checks++;
    if (bus.seg !== S2) begin failures++; $display("FAIL blink_vis_end got=%b exp=%b", bus.seg, S2); end
    step(1);
    checks++;
    if (bus.seg !== 7'b0) begin failures++; $display("FAIL blink_blank got=%b exp=0000000", bus.seg); end
    step(24);
    checks++;
    if (bus.seg !== 7'b0) begin failures++; $display("FAIL blink_blank_end got=%b exp=0000000", bus.seg); end
    step(1);
    checks++;
    if (bus.seg !== S2) begin failures++; $display("FAIL blink_vis2 got=%b exp=%b", bus.seg, S2); end
    step(69);
    checks++;
    if (bus.seg !== S2 || bus.alarm_led !== 1'b1) begin
      failures++; $display("FAIL blink_last got=%b/%b exp=%b/1", bus.seg, bus.alarm_led, S2);
    end
    bus.sos_mode = 1'b0;
    step(1);
    checks++;
    if (bus.alarm_led !== 1'b0) begin failures++; $display("FAIL alarm_led_off got=%b exp=0", bus.alarm_led); end
    step(30);
    checks++;
    if (bus.seg !== S2) begin failures++; $display("FAIL seg_solid got=%b exp=%b", bus.seg, S2); end
  endtask

  task automatic test_fault;
    set_floor(3'b000);
    step(2);
    checks++;
    if (bus.fault !== 1'b0) begin failures++; $display("FAIL fault_early got=%b exp=0", bus.fault); end
    step(1);
    checks++;
    if (bus.fault !== 1'b1 || bus.seg !== SD) begin
      failures++; $display("FAIL fault_set got=%b/%b exp=1/%b", bus.fault, bus.seg, SD);
    end
    checks++;
    if ({bus.dir_up, bus.dir_down} !== 2'b00) begin
      failures++; $display("FAIL fault_dir_hold got=%b exp=00", {bus.dir_up, bus.dir_down});
    end
    set_floor(3'b100);
    step(3);
    checks++;
    if (bus.fault !== 1'b0 || bus.seg !== S3) begin
      failures++; $display("FAIL fault_clear got=%b/%b exp=0/%b", bus.fault, bus.seg, S3);
    end
    checks++;
    if ({bus.dir_up, bus.dir_down} !== 2'b10) begin
      failures++; $display("FAIL dir_up_2to3 got=%b exp=10", {bus.dir_up, bus.dir_down});
    end
  endtask

  task automatic test_back_to_back;
    set_floor(3'b010);
    step(3);
    checks++;
    if ({bus.dir_up, bus.dir_down} !== 2'b01 || bus.seg !== S2) begin
      failures++; $display("FAIL dir_down_3to2 got=%b/%b exp=01/%b", {bus.dir_up, bus.dir_down}, bus.seg, S2);
    end
    bus.moving = 1'b1;
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.seg !== S1) begin failures++; $display("FAIL async_rst_seg got=%b exp=%b", bus.seg, S1); end
    checks++;
    if ({bus.dir_up, bus.dir_down, bus.chime, bus.alarm_led, bus.fault} !== 5'b0) begin
      failures++; $display("FAIL async_rst_flags got=%b exp=00000",
        {bus.dir_up, bus.dir_down, bus.chime, bus.alarm_led, bus.fault});
    end
    set_floor(3'b001);
    bus.moving = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    checks++;
    if (bus.seg !== S1 || bus.fault !== 1'b0) begin
      failures++; $display("FAIL post_async_rst got=%b/%b exp=%b/0", bus.seg, bus.fault, S1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_floor_up();
    test_glitch();
    test_chime();
    test_alarm();
    test_fault();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
